// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, synchronous-imem address generation and
// a direct-mapped BTB of 2-bit counters, with prediction aligned to the imem output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] if_pc,
  output logic        if_flush,
  output logic        if_pred_valid,
  output logic        if_pred_taken,
  output logic [31:0] if_predicted_pc
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Fetch state
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] next_pc;

  // BTB storage
  logic [BTB_ENTRIES-1:0] btb_valid;
  tag_t                   btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  // Lookup side
  idx_t        look_idx;
  tag_t        look_tag;
  logic        look_hit;
  logic        look_taken;
  logic [31:0] seq_pc;

  // Training side
  idx_t        upd_idx;
  tag_t        upd_tag;
  logic        upd_hit;
  logic        btb_write;
  logic [1:0]  ctr_next;
  logic        unused_bits;

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational on the PC of the instruction now on the imem
  // output, so it always sees the pre-edge BTB contents.
  // ---------------------------------------------------------------------------
  assign look_idx   = pc_q[IDX_W+1:2];
  assign look_tag   = pc_q[31:IDX_W+2];
  assign look_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign look_taken = look_hit && btb_ctr[look_idx][1];
  assign seq_pc     = pc_q + 32'd4;

  assign if_pc           = pc_q;
  assign if_flush        = ~valid_q;
  assign if_pred_valid   = look_hit;
  assign if_pred_taken   = look_taken;
  assign if_predicted_pc = look_taken ? btb_target[look_idx] : seq_pc;

  // ---------------------------------------------------------------------------
  // Next fetch address. A redirect beats everything, including a stall; before
  // the first enabled edge the reset PC is simply fetched again.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of an always_comb gets a value on entry; a path that
    // leaves it unassigned would infer a latch.
    next_pc = if_predicted_pc;
    if (ex_redirect) begin
      next_pc = ex_redirect_pc;
    end else if (!valid_q || !pipeline_en) begin
      next_pc = pc_q;
    end
  end

  assign imem_addr = next_pc;
  assign imem_en   = ex_redirect | pipeline_en;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs as they were before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (imem_en) begin
      pc_q    <= next_pc;
      valid_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Training. Misses that were not taken leave the BTB alone; a taken miss
  // allocates weakly-taken, overwriting whatever aliased into that slot.
  // ---------------------------------------------------------------------------
  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[31:IDX_W+2];
  assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  assign btb_write   = upd_valid && (upd_hit || upd_taken);
  assign unused_bits = ^upd_pc[1:0];

  always_comb begin
    ctr_next = 2'b10;
    if (upd_hit) begin
      ctr_next = btb_ctr[upd_idx];
      if (upd_taken && (btb_ctr[upd_idx] != 2'b11)) begin
        ctr_next = btb_ctr[upd_idx] + 2'b01;
      end else if (!upd_taken && (btb_ctr[upd_idx] != 2'b00)) begin
        ctr_next = btb_ctr[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (btb_write) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  // NOTE: only the valid bits are reset; tag, target and counter arrays are
  // plain storage that is never read while its valid bit is clear, so they
  // carry no reset and can map onto RAM-style cells.
  always_ff @(posedge clk) begin
    if (btb_write) begin
      btb_tag[upd_idx] <= upd_tag;
      btb_ctr[upd_idx] <= ctr_next;
      if (upd_taken) begin
        btb_target[upd_idx] <= upd_target;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// scored against a word-address-level model of the PC and branch-target buffer.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          N        = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_en, ex_redirect, upd_valid, upd_taken;
  logic [31:0] ex_redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, if_pc, if_predicted_pc;
  logic        imem_en, if_flush, if_pred_valid, if_pred_taken;

  fetch_unit #(.RESET_PC(RESET_PC), .BTB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst),
    .pipeline_en(pipeline_en), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .imem_addr(imem_addr), .imem_en(imem_en), .if_pc(if_pc), .if_flush(if_flush),
    .if_pred_valid(if_pred_valid), .if_pred_taken(if_pred_taken),
    .if_predicted_pc(if_predicted_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries remember the full word address of the branch they describe.
  logic [31:0] m_pc;
  logic        m_valid;
  bit          m_bv  [N];
  logic [29:0] m_bwa [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        pt;
    logic [31:0] ppc;
  } exp_t;
  exp_t q[$];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_bv[m_idx(pc)] && (m_bwa[m_idx(pc)] == pc[31:2]);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
  endtask

  task automatic m_train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    if (m_hit(pc)) begin
      m_ctr[i] = taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                       : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
      if (taken) m_tgt[i] = tgt;
    end else if (taken) begin
      m_bv[i]  = 1'b1;
      m_bwa[i] = pc[31:2];
      m_tgt[i] = tgt;
      m_ctr[i] = 2;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies one cycle of stimulus and returns at the next.
  task automatic step(input logic pe, input logic rd, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt);
    logic [31:0] nxt;
    logic        en;
    exp_t        e;
    pipeline_en = pe; ex_redirect = rd; ex_redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    en = rd | pe;
    if (rd)                   nxt = rpc;
    else if (!m_valid || !pe) nxt = m_pc;
    else                      nxt = m_pred_pc(m_pc);
    #1;
    check("imem_addr", imem_addr, nxt);
    check("imem_en", {31'd0, imem_en}, {31'd0, en});
    check("if_flush", {31'd0, if_flush}, {31'd0, !m_valid});
    if (uv) m_train(upc, ut, utgt);
    if (en) begin
      m_pc    = nxt;
      m_valid = 1'b1;
      e.pc  = m_pc;
      e.pv  = m_hit(m_pc);
      e.pt  = m_taken(m_pc);
      e.ppc = m_pred_pc(m_pc);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic pe);
    step(pe, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_if_pc", if_pc, RESET_PC);
    check("rst_if_flush", {31'd0, if_flush}, 32'd1);
    check("rst_pred_valid", {31'd0, if_pred_valid}, 32'd0);
    check("rst_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    check("rst_predicted_pc", if_predicted_pc, RESET_PC + 32'd4);
    m_reset();
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return 32'h100 + 32'd4 * 32'($urandom_range(0, 23));
  endfunction

  // ---------------- monitor ----------------
  // Each enabled edge puts a new instruction on the imem output; score it.
  initial begin
    bit   issued;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      issued = imem_en && !rst;
      @(posedge clk);
      #1;
      if (issued) begin
        if (q.size() == 0) begin
          check("mon_queue_empty", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("mon_if_pc", if_pc, e.pc);
          check("mon_if_flush", {31'd0, if_flush}, 32'd0);
          check("mon_pred_valid", {31'd0, if_pred_valid}, {31'd0, e.pv});
          check("mon_pred_taken", {31'd0, if_pred_taken}, {31'd0, e.pt});
          check("mon_predicted_pc", if_predicted_pc, e.ppc);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    pipeline_en = 0; ex_redirect = 0; ex_redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Start-up latency and sequential fetch with an empty BTB
    idle(1'b1);
    check("t1_if_pc", if_pc, 32'h100);
    check("t1_if_flush", {31'd0, if_flush}, 32'd0);
    check("t1_imem_addr", imem_addr, 32'h104);
    idle(1'b1);
    idle(1'b1);
    check("t2_if_pc", if_pc, 32'h108);
    check("t2_pred_valid", {31'd0, if_pred_valid}, 32'd0);
    repeat (3) idle(1'b0);
    check("t2_stall_if_pc", if_pc, 32'h108);
    check("t2_stall_imem_en", {31'd0, imem_en}, 32'd0);

    // Redirect while stalled
    step(1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t3_if_pc", if_pc, 32'h200);

    // Allocate a taken branch, then fetch it
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h108, 1'b1, 32'h300);
    step(1'b0, 1'b1, 32'h108, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t4_pred_valid", {31'd0, if_pred_valid}, 32'd1);
    check("t4_pred_taken", {31'd0, if_pred_taken}, 32'd1);
    check("t4_predicted_pc", if_predicted_pc, 32'h300);
    idle(1'b1);
    check("t4_if_pc", if_pc, 32'h300);

    // Counter walks down to 0, then saturates at 3
    step(1'b0, 1'b1, 32'h108, 1'b1, 32'h108, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h108, 1'b0, 32'd0);
    check("t5_nt_pred_valid", {31'd0, if_pred_valid}, 32'd1);
    check("t5_nt_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    check("t5_nt_predicted_pc", if_predicted_pc, 32'h10C);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1, 32'h108, 1'b1, 32'h300);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h108, 1'b0, 32'd0);
    check("t5_sat_pred_taken", {31'd0, if_pred_taken}, 32'd1);
    check("t5_sat_predicted_pc", if_predicted_pc, 32'h300);

    // Mid-run reset clears the BTB; same-cycle allocate is not bypassed
    do_reset();
    idle(1'b1);
    step(1'b0, 1'b1, 32'h108, 1'b0, 32'd0, 1'b0, 32'd0);
    pipeline_en = 0; ex_redirect = 0;
    upd_valid = 1; upd_pc = 32'h108; upd_taken = 1; upd_target = 32'h400;
    #1;
    check("t6_same_cycle_pred_valid", {31'd0, if_pred_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h108, 1'b1, 32'h400);
    check("t6_alloc_pred_valid", {31'd0, if_pred_valid}, 32'd1);
    check("t6_alloc_predicted_pc", if_predicted_pc, 32'h400);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h108 + 32'd4 * N, 1'b1, 32'h500);
    check("t6_alias_pred_valid", {31'd0, if_pred_valid}, 32'd0);
    check("t6_alias_predicted_pc", if_predicted_pc, 32'h10C);

    // PC wraps past the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(1'b1);
    check("t7_wrap_if_pc", if_pc, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0, rand_pc(),
             $urandom_range(0, 2) == 0, rand_pc() | 32'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, rand_pc());
      end
    end

    repeat (3) idle(1'b0);
    check("end_queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
